// File: rtl/cronometro_bcd.sv
// rtl/cronometro_bcd.sv - stopwatch core: 0.1 s prescaler, BCD cascade 0:00.0..9:59.9, start/stop/lap/clear FSM
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   start_stop  level input, rising edge toggles run/stop
//   lap         level input, rising edge toggles lap freeze while running
//   clear       level input, rising edge zeroes count and prescaler when stopped
//   count       tenths digit (0-9), registered
//   dec         seconds units digit (0-9), registered
//   cent        seconds tens digit (0-5), registered
//   mil         minutes digit (0-9), registered
//   running     high in RUN and LAP
//   frozen      high in LAP
//   wrap        one-cycle pulse together with the 9:59.9 -> 0:00.0 display update
module cronometro_bcd #(
    parameter int DIV = 5_000_000,
    parameter int N   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_stop,
    input  logic         lap,
    input  logic         clear,
    output logic [N-1:0] count,
    output logic [N-1:0] dec,
    output logic [N-1:0] cent,
    output logic [N-1:0] mil,
    output logic         running,
    output logic         frozen,
    output logic         wrap
);

    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [N-1:0]  D0 = '0;
    localparam logic [N-1:0]  D5 = N'(5);
    localparam logic [N-1:0]  D9 = N'(9);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            start_prev_q, lap_prev_q, clear_prev_q;
    logic [PW-1:0]   presc_q, presc_d;
    logic [4*N-1:0]  live_q, live_d;
    logic [4*N-1:0]  frz_q, frz_d;
    logic [4*N-1:0]  out_q, out_d;
    logic            running_q, frozen_q, wrap_q, wrap_d;

    logic start_edge, lap_edge, clear_edge;
    logic cnt_en, do_clear, capture, show_frz, tick;

    assign start_edge = start_stop & ~start_prev_q;
    assign lap_edge   = lap & ~lap_prev_q;
    assign clear_edge = clear & ~clear_prev_q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_STOP;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; clear beats start in STOP, start beats lap elsewhere
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: begin
                if (clear_edge) begin
                    state_d = ST_STOP;
                end else if (start_edge) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (start_edge) begin
                    state_d = ST_STOP;
                end else if (lap_edge) begin
                    state_d = ST_LAP;
                end
            end
            ST_LAP: begin
                if (start_edge) begin
                    state_d = ST_STOP;
                end else if (lap_edge) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_STOP;
        endcase
    end

    // FSM outputs
    always_comb begin
        cnt_en   = 1'b0;
        do_clear = 1'b0;
        capture  = 1'b0;
        show_frz = 1'b0;
        case (state_q)
            ST_STOP: do_clear = clear_edge;
            ST_RUN: begin
                cnt_en  = 1'b1;
                capture = lap_edge & ~start_edge;
            end
            ST_LAP:  cnt_en = 1'b1;
            default: cnt_en = 1'b0;
        endcase
        // The output register follows the state being entered, so a freeze
        // takes effect on the first cycle after the lap edge.
        show_frz = (state_d == ST_LAP);
    end

    assign tick = cnt_en && (presc_q == PRESC_LAST);

    // Prescaler holds in STOP so a resumed run keeps its partial interval
    always_comb begin
        presc_d = presc_q;
        if (do_clear) begin
            presc_d = '0;
        end else if (cnt_en) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
    end

    // BCD cascade: live_q = {mil, cent, dec, count}
    always_comb begin
        live_d = live_q;
        wrap_d = 1'b0;
        if (do_clear) begin
            live_d = '0;
        end else if (tick) begin
            if (live_q[N-1:0] != D9) begin
                live_d[N-1:0] = live_q[N-1:0] + N'(1);
            end else begin
                live_d[N-1:0] = D0;
                if (live_q[2*N-1:N] != D9) begin
                    live_d[2*N-1:N] = live_q[2*N-1:N] + N'(1);
                end else begin
                    live_d[2*N-1:N] = D0;
                    if (live_q[3*N-1:2*N] != D5) begin
                        live_d[3*N-1:2*N] = live_q[3*N-1:2*N] + N'(1);
                    end else begin
                        live_d[3*N-1:2*N] = D0;
                        if (live_q[4*N-1:3*N] != D9) begin
                            live_d[4*N-1:3*N] = live_q[4*N-1:3*N] + N'(1);
                        end else begin
                            live_d[4*N-1:3*N] = D0;
                            wrap_d            = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // The freeze copy takes the pre-tick live value, hiding a tick in the lap cycle
    assign frz_d = capture ? live_q : frz_q;
    assign out_d = show_frz ? frz_d : live_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            start_prev_q <= 1'b0;
            lap_prev_q   <= 1'b0;
            clear_prev_q <= 1'b0;
            presc_q      <= '0;
            live_q       <= '0;
            frz_q        <= '0;
            out_q        <= '0;
            running_q    <= 1'b0;
            frozen_q     <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            start_prev_q <= start_stop;
            lap_prev_q   <= lap;
            clear_prev_q <= clear;
            presc_q      <= presc_d;
            live_q       <= live_d;
            frz_q        <= frz_d;
            out_q        <= out_d;
            running_q    <= (state_d != ST_STOP);
            frozen_q     <= (state_d == ST_LAP);
            wrap_q       <= wrap_d;
        end
    end

    assign count   = out_q[N-1:0];
    assign dec     = out_q[2*N-1:N];
    assign cent    = out_q[3*N-1:2*N];
    assign mil     = out_q[4*N-1:3*N];
    assign running = running_q;
    assign frozen  = frozen_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_cronometro_bcd.sv
// tb/tb_cronometro_bcd.sv - self-checking bench for cronometro_bcd with DIV=4
module tb_cronometro_bcd;

    localparam int DIV = 4;
    localparam int N   = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_stop = 1'b0;
    logic         lap = 1'b0;
    logic         clear = 1'b0;
    logic [N-1:0] count, dec, cent, mil;
    logic         running, frozen, wrap;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] sb[$];
    logic [15:0] exp_d;
    logic [15:0] shown;

    assign shown = {mil, cent, dec, count};

    cronometro_bcd #(.DIV(DIV), .N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .count      (count),
        .dec        (dec),
        .cent       (cent),
        .mil        (mil),
        .running    (running),
        .frozen     (frozen),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    // Display value expected after t elapsed tenths, as {mil, cent, dec, count}
    function automatic logic [15:0] bcd(input int t);
        bcd = {4'((t / 600) % 10), 4'((t / 100) % 6), 4'((t / 10) % 10), 4'(t % 10)};
    endfunction

    // All stimulus moves on the falling edge; the DUT samples on the rising edge
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic s, input logic l, input logic c);
        start_stop = s;
        lap        = l;
        clear      = c;
        @(negedge clk);
        start_stop = 1'b0;
        lap        = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        start_stop = 1'b1;
        lap        = 1'b1;
        clear      = 1'b1;
        rst        = 1'b1;
        sb.push_back(bcd(0));
        step(3);
        exp_d = sb.pop_front();
        n_checks++;
        if (shown !== exp_d) begin
            n_fail++;
            $display("FAIL reset_digits got %h expected %h", shown, exp_d);
        end
        n_checks++;
        if ({running, frozen, wrap} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags got %b expected 000", {running, frozen, wrap});
        end
        rst = 1'b0;
        step(1);
        n_checks++;
        if (running !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_running got %b expected 0", running);
        end
        sb.push_back(bcd(0));
        step(12);
        exp_d = sb.pop_front();
        n_checks++;
        if (shown !== exp_d || running !== 1'b0 || frozen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle got %h run %b frz %b expected %h run 0 frz 0",
                     shown, running, frozen, exp_d);
        end
        start_stop = 1'b0;
        lap        = 1'b0;
        clear      = 1'b0;
        step(2);
    endtask

    task automatic test_basic_count();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (running !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_running got %b expected 1", running);
        end
        sb.push_back(bcd(10));
        step(40);
        exp_d = sb.pop_front();
        n_checks++;
        if (shown !== exp_d) begin
            n_fail++;
            $display("FAIL basic_40_cycles got %h expected %h", shown, exp_d);
        end
        pulse(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (running !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_stop_running got %b expected 0", running);
        end
        sb.push_back(bcd(10));
        step(100);
        exp_d = sb.pop_front();
        n_checks++;
        if (shown !== exp_d) begin
            n_fail++;
            $display("FAIL basic_hold got %h expected %h", shown, exp_d);
        end
    endtask

    task automatic test_full_wrap();
        int wraps;
        int wrap_at;
        int bad;
        wraps   = 0;
        wrap_at = -1;
        bad     = 0;
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        sb.push_back(bcd(5999));
        sb.push_back(bcd(6000));
        for (int i = 1; i <= 24004; i++) begin
            step(1);
            if (wrap === 1'b1) begin
                wraps++;
                wrap_at = i;
            end
            if (count > 4'd9 || dec > 4'd9 || cent > 4'd5 || mil > 4'd9) bad++;
            if (i == 23996 || i == 24000) begin
                exp_d = sb.pop_front();
                n_checks++;
                if (shown !== exp_d) begin
                    n_fail++;
                    $display("FAIL wrap_digits cycle %0d got %h expected %h", i, shown, exp_d);
                end
            end
        end
        n_checks++;
        if (wraps !== 1 || wrap_at !== 24000) begin
            n_fail++;
            $display("FAIL wrap_pulse got %0d pulses at cycle %0d expected 1 at 24000", wraps, wrap_at);
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL wrap_digit_range got %0d out-of-range cycles expected 0", bad);
        end
    endtask

    task automatic test_lap();
        int moved;
        moved = 0;
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        sb.push_back(bcd(12));
        step(48);
        exp_d = sb.pop_front();
        n_checks++;
        if (shown !== exp_d) begin
            n_fail++;
            $display("FAIL lap_before got %h expected %h", shown, exp_d);
        end
        pulse(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (frozen !== 1'b1 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL lap_enter_flags got frz %b run %b expected frz 1 run 1", frozen, running);
        end
        sb.push_back(bcd(12));
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (shown !== bcd(12)) moved++;
        end
        exp_d = sb.pop_front();
        n_checks++;
        if (shown !== exp_d || moved !== 0) begin
            n_fail++;
            $display("FAIL lap_frozen got %h (%0d moved cycles) expected %h", shown, moved, exp_d);
        end
        sb.push_back(bcd(17));
        pulse(1'b0, 1'b1, 1'b0);
        exp_d = sb.pop_front();
        n_checks++;
        if (shown !== exp_d || frozen !== 1'b0 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL lap_release got %h frz %b run %b expected %h frz 0 run 1",
                     shown, frozen, running, exp_d);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        step(10);
        sb.push_back(bcd(2));
        pulse(1'b1, 1'b1, 1'b0);
        exp_d = sb.pop_front();
        n_checks++;
        if (shown !== exp_d || running !== 1'b0 || frozen !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_start_lap got %h run %b frz %b expected %h run 0 frz 0",
                     shown, running, frozen, exp_d);
        end
        step(4);
        sb.push_back(bcd(0));
        pulse(1'b1, 1'b0, 1'b1);
        exp_d = sb.pop_front();
        n_checks++;
        if (shown !== exp_d || running !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_start_clear got %h run %b expected %h run 0", shown, running, exp_d);
        end
        sb.push_back(bcd(0));
        step(20);
        exp_d = sb.pop_front();
        n_checks++;
        if (shown !== exp_d || running !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_clear_idle got %h run %b expected %h run 0", shown, running, exp_d);
        end
    endtask

    task automatic test_clear_resume();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        step(6);
        pulse(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (running !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_in_run_running got %b expected 1", running);
        end
        sb.push_back(bcd(2));
        step(1);
        exp_d = sb.pop_front();
        n_checks++;
        if (shown !== exp_d) begin
            n_fail++;
            $display("FAIL clear_in_run_ignored got %h expected %h", shown, exp_d);
        end
        step(1);
        pulse(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (running !== 1'b0) begin
            n_fail++;
            $display("FAIL resume_stop_running got %b expected 0", running);
        end
        sb.push_back(bcd(2));
        step(5);
        exp_d = sb.pop_front();
        n_checks++;
        if (shown !== exp_d) begin
            n_fail++;
            $display("FAIL resume_stopped got %h expected %h", shown, exp_d);
        end
        pulse(1'b1, 1'b0, 1'b0);
        sb.push_back(bcd(2));
        sb.push_back(bcd(3));
        step(1);
        exp_d = sb.pop_front();
        n_checks++;
        if (shown !== exp_d) begin
            n_fail++;
            $display("FAIL resume_early got %h expected %h", shown, exp_d);
        end
        step(1);
        exp_d = sb.pop_front();
        n_checks++;
        if (shown !== exp_d) begin
            n_fail++;
            $display("FAIL resume_tick got %h expected %h", shown, exp_d);
        end
    endtask

    initial begin
        step(1);
        test_reset();
        test_basic_count();
        test_full_wrap();
        test_lap();
        test_simultaneous();
        test_clear_resume();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
